// File: rtl/xor4_rr_arbiter_pkg.sv
// Shared constants, state encoding and lane-select helper for the
// round-robin XOR arbiter.
package xor4_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int DW    = 4;
  localparam int IDW   = 2;
  localparam int CW    = 8;

  // Pointer value that makes requester 0 the first choice out of reset.
  localparam logic [IDW-1:0] RR_RESET_LAST = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic logic [DW-1:0] lane_sel(
    input logic [N_REQ*DW-1:0] bus,
    input logic [IDW-1:0]      idx
  );
    logic [DW-1:0] lane;
    case (idx)
      2'd0:    lane = bus[3:0];
      2'd1:    lane = bus[7:4];
      2'd2:    lane = bus[11:8];
      2'd3:    lane = bus[15:12];
      default: lane = bus[3:0];
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/xor4_rr_arbiter_chk.sv
// Protocol checker for xor4_rr_arbiter: grant shape, stall behaviour and
// output stability under backpressure.
module xor4_rr_arbiter_chk
  import xor4_rr_arbiter_pkg::*;
(
  input logic             clk,
  input logic             reset,
  input logic [N_REQ-1:0] gnt,
  input logic             z_valid,
  input logic             z_ready,
  input logic [DW-1:0]    z_out,
  input logic [IDW-1:0]   z_id
);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(gnt));

  a_gnt_stall: assert property (@(posedge clk) disable iff (reset)
    (z_valid && !z_ready) |-> (gnt == 4'b0000));

  a_hold_stall: assert property (@(posedge clk) disable iff (reset)
    (z_valid && !z_ready) |=> ($stable(z_out) && $stable(z_id)));

endmodule

// File: rtl/xor4_rr_arbiter_pick.sv
// Combinational round-robin picker: searches upward from last+1, wrapping,
// and returns a one-hot grant plus its index.
module rr_pick4
  import xor4_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   idx
);

  logic             found_s;
  logic [IDW-1:0]   cand_s;

  always_comb begin
    gnt     = 4'b0000;
    idx     = 2'd0;
    found_s = 1'b0;
    cand_s  = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      // 2-bit addition wraps naturally back to requester 0.
      cand_s = last + 2'd1 + i[IDW-1:0];
      if (en && !found_s && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/xor_4bit.sv
// Plain 4-bit bitwise XOR datapath, shared by all requesters.
module xor_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] z
);

  assign z = a ^ b;

endmodule

// File: rtl/xor4_rr_arbiter.sv
// Four requesters share one xor_4bit through a round-robin grant; the result
// lands in a one-entry valid/ready output register tagged with its source.
module xor4_rr_arbiter
  import xor4_rr_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] x_in,
  input  logic [N_REQ*DW-1:0] y_in,
  output logic [N_REQ-1:0]    gnt,
  output logic [DW-1:0]       z_out,
  output logic [IDW-1:0]      z_id,
  output logic                z_valid,
  input  logic                z_ready,
  output logic [CW-1:0]       op_cnt
);

  state_e          state_q, state_d;
  logic [DW-1:0]   z_out_q, z_out_d;
  logic [IDW-1:0]  z_id_q,  z_id_d;
  logic [IDW-1:0]  last_q,  last_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  logic            free_s;
  logic            en_s;
  logic            xfer_s;
  logic [N_REQ-1:0] gnt_s;
  logic [IDW-1:0]  idx_s;
  logic [DW-1:0]   x_sel_s;
  logic [DW-1:0]   y_sel_s;
  logic [DW-1:0]   z_s;

  // The picker is enabled only when the slot is free and reset is low.
  assign free_s = (state_q == ST_EMPTY) || z_ready;
  assign en_s   = free_s && !reset;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_q),
    .en   (en_s),
    .gnt  (gnt_s),
    .idx  (idx_s)
  );

  assign xfer_s  = |(req & gnt_s);
  assign x_sel_s = lane_sel(x_in, idx_s);
  assign y_sel_s = lane_sel(y_in, idx_s);

  xor_4bit u_xor (
    .a (x_sel_s),
    .b (y_sel_s),
    .z (z_s)
  );

  always_comb begin
    state_d = state_q;
    z_out_d = z_out_q;
    z_id_d  = z_id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (xfer_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer_s) begin
          state_d = ST_FULL;
        end else if (z_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // A new result overwrites the slot; otherwise data holds even when consumed.
    if (xfer_s) begin
      z_out_d = z_s;
      z_id_d  = idx_s;
      last_d  = idx_s;
      cnt_d   = cnt_q + 8'd1;
    end else begin
      z_out_d = z_out_q;
      z_id_d  = z_id_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      z_out_q <= 4'h0;
      z_id_q  <= 2'd0;
      last_q  <= RR_RESET_LAST;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      z_out_q <= z_out_d;
      z_id_q  <= z_id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt     = gnt_s;
  assign z_valid = (state_q == ST_FULL);
  assign z_out   = z_out_q;
  assign z_id    = z_id_q;
  assign op_cnt  = cnt_q;

endmodule

// File: tb/tb_xor4_rr_arbiter.sv
// Directed, table-driven bench for xor4_rr_arbiter with hand-written
// sequences for counter wrap and asynchronous reset.
module tb_xor4_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [15:0] x_in = 16'h0000;
  logic [15:0] y_in = 16'h0000;
  logic [3:0]  gnt;
  logic [3:0]  z_out;
  logic [1:0]  z_id;
  logic        z_valid;
  logic        z_ready = 1'b0;
  logic [7:0]  op_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] x;
    logic [15:0] y;
    logic        rdy;
    logic [3:0]  gnt;
    logic [3:0]  z;
    logic [1:0]  id;
    logic        v;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  xor4_rr_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .x_in    (x_in),
    .y_in    (y_in),
    .gnt     (gnt),
    .z_out   (z_out),
    .z_id    (z_id),
    .z_valid (z_valid),
    .z_ready (z_ready),
    .op_cnt  (op_cnt)
  );

  xor4_rr_arbiter_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .gnt     (gnt),
    .z_valid (z_valid),
    .z_ready (z_ready),
    .z_out   (z_out),
    .z_id    (z_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req     = 4'b0000;
    z_ready = 1'b0;
    x_in    = 16'h0000;
    y_in    = 16'h0000;
    @(posedge clk);
    #1;
    chk("rst_gnt", {12'h0, gnt}, 16'h0000);
    chk("rst_valid", {15'h0, z_valid}, 16'h0000);
    chk("rst_cnt", {8'h0, op_cnt}, 16'h0000);
    chk("rst_zout", {12'h0, z_out}, 16'h0000);
    chk("rst_zid", {14'h0, z_id}, 16'h0000);
    reset = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    req     = v.req;
    x_in    = v.x;
    y_in    = v.y;
    z_ready = v.rdy;
    #3;
    chk($sformatf("v%0d_gnt", n), {12'h0, gnt}, {12'h0, v.gnt});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_zout", n), {12'h0, z_out}, {12'h0, v.z});
    chk($sformatf("v%0d_zid", n), {14'h0, z_id}, {14'h0, v.id});
    chk($sformatf("v%0d_valid", n), {15'h0, z_valid}, {15'h0, v.v});
    chk($sformatf("v%0d_cnt", n), {8'h0, op_cnt}, {8'h0, v.cnt});
  endtask

  initial begin
    // req, x, y, rdy | gnt, z, id, v, cnt
    vecs.push_back('{4'b0001, 16'h000A, 16'h0005, 1'b1, 4'b0001, 4'hF, 2'd0, 1'b1, 8'd1});
    vecs.push_back('{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 4'hF, 2'd0, 1'b0, 8'd1});
    vecs.push_back('{4'b1000, 16'h3210, 16'hFFFF, 1'b1, 4'b1000, 4'hC, 2'd3, 1'b1, 8'd2});
    vecs.push_back('{4'b1111, 16'h3210, 16'hFFFF, 1'b1, 4'b0001, 4'hF, 2'd0, 1'b1, 8'd3});
    vecs.push_back('{4'b1111, 16'h3210, 16'hFFFF, 1'b1, 4'b0010, 4'hE, 2'd1, 1'b1, 8'd4});
    vecs.push_back('{4'b1111, 16'h3210, 16'hFFFF, 1'b1, 4'b0100, 4'hD, 2'd2, 1'b1, 8'd5});
    vecs.push_back('{4'b1111, 16'h3210, 16'hFFFF, 1'b1, 4'b1000, 4'hC, 2'd3, 1'b1, 8'd6});
    vecs.push_back('{4'b1111, 16'h3210, 16'hFFFF, 1'b1, 4'b0001, 4'hF, 2'd0, 1'b1, 8'd7});
    vecs.push_back('{4'b0100, 16'h3210, 16'hFFFF, 1'b1, 4'b0100, 4'hD, 2'd2, 1'b1, 8'd8});
    vecs.push_back('{4'b1010, 16'h3210, 16'hFFFF, 1'b0, 4'b0000, 4'hD, 2'd2, 1'b1, 8'd8});
    vecs.push_back('{4'b1010, 16'h3210, 16'hFFFF, 1'b0, 4'b0000, 4'hD, 2'd2, 1'b1, 8'd8});
    vecs.push_back('{4'b1010, 16'h3210, 16'hFFFF, 1'b0, 4'b0000, 4'hD, 2'd2, 1'b1, 8'd8});
    vecs.push_back('{4'b1010, 16'h3210, 16'hFFFF, 1'b1, 4'b1000, 4'hC, 2'd3, 1'b1, 8'd9});
    vecs.push_back('{4'b0010, 16'h0030, 16'h0060, 1'b1, 4'b0010, 4'h5, 2'd1, 1'b1, 8'd10});
    vecs.push_back('{4'b0010, 16'h0030, 16'h0060, 1'b1, 4'b0010, 4'h5, 2'd1, 1'b1, 8'd11});
    vecs.push_back('{4'b0010, 16'h0030, 16'h0060, 1'b1, 4'b0010, 4'h5, 2'd1, 1'b1, 8'd12});
    vecs.push_back('{4'b0001, 16'h0030, 16'h0066, 1'b0, 4'b0000, 4'h5, 2'd1, 1'b1, 8'd12});
    vecs.push_back('{4'b0000, 16'h0030, 16'h0066, 1'b0, 4'b0000, 4'h5, 2'd1, 1'b1, 8'd12});
    vecs.push_back('{4'b0000, 16'h0030, 16'h0066, 1'b1, 4'b0000, 4'h5, 2'd1, 1'b0, 8'd12});
    vecs.push_back('{4'b0011, 16'h0030, 16'h0066, 1'b1, 4'b0001, 4'h6, 2'd0, 1'b1, 8'd13});
    vecs.push_back('{4'b0011, 16'h0030, 16'h0066, 1'b1, 4'b0010, 4'h5, 2'd1, 1'b1, 8'd14});

    do_reset();
    for (int n = 0; n < vecs.size(); n++) begin
      run_vec(n, vecs[n]);
    end

    // Counter wrap: 256 back-to-back transfers from requester 0.
    do_reset();
    req     = 4'b0001;
    z_ready = 1'b1;
    x_in    = 16'h0007;
    y_in    = 16'h0001;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("wrap_cnt%0d", i), {8'h0, op_cnt}, 16'((i + 1) % 256));
    end
    chk("wrap_valid", {15'h0, z_valid}, 16'h0001);
    chk("wrap_zout", {12'h0, z_out}, 16'h0006);

    // Asynchronous reset between edges while a result is pending.
    req     = 4'b0100;
    z_ready = 1'b0;
    x_in    = 16'h0009;
    y_in    = 16'h0003;
    #2;
    chk("ar_pre_valid", {15'h0, z_valid}, 16'h0001);
    reset = 1'b1;
    #1;
    chk("ar_valid", {15'h0, z_valid}, 16'h0000);
    chk("ar_gnt", {12'h0, gnt}, 16'h0000);
    chk("ar_cnt", {8'h0, op_cnt}, 16'h0000);
    chk("ar_zout", {12'h0, z_out}, 16'h0000);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    req     = 4'b0101;
    z_ready = 1'b1;
    #3;
    chk("ar_first_gnt", {12'h0, gnt}, 16'h0001);
    @(posedge clk);
    #1;
    chk("ar_first_zid", {14'h0, z_id}, 16'h0000);
    chk("ar_first_zout", {12'h0, z_out}, 16'h000A);
    chk("ar_first_cnt", {8'h0, op_cnt}, 16'h0001);
    chk("ar_first_valid", {15'h0, z_valid}, 16'h0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
